// File: rtl/eprisc_serial_pkg.sv
// Shared types and helpers for the eprisc serial transmitter, receiver and benches.
package eprisc_serial_pkg;

  typedef enum logic [1:0] {
    ParNone = 2'd0,
    ParOdd  = 2'd1,
    ParEven = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StGap,
    StBreak
  } tx_state_e;

  // Wide enough for DATA_BITS (<=9), STOP_BITS (<=2) and GAP_BITS (<=15).
  localparam int unsigned BitCntW = 4;

  function automatic int unsigned frame_cycles(input int unsigned data_bits,
                                               input int unsigned parity,
                                               input int unsigned stop_bits,
                                               input int unsigned gap_bits,
                                               input int unsigned divisor);
    int unsigned bits;
    bits = 1 + data_bits + stop_bits + gap_bits;
    if (parity != 0) bits = bits + 1;
    return bits * divisor;
  endfunction

endpackage

// File: rtl/eprisc_sync_fifo.sv
// Synchronous show-ahead FIFO with registered occupancy count.
module eprisc_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] CountFull = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  always_comb begin
    full_o  = (count_q == CountFull);
    empty_o = (count_q == '0);
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    rdata_o = mem_q[rd_ptr_q];
    count_o = count_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/eprisc_serial_tx.sv
// Buffered asynchronous serial transmitter: FIFO-fed start/data/parity/stop framing,
// flow-control hold at frame boundaries and line-break generation.
module eprisc_serial_tx
  import eprisc_serial_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned DIVISOR    = 256,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned GAP_BITS   = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          iBoardClock,
  input  logic                          iBoardReset,
  input  logic [DATA_BITS-1:0]          iData,
  input  logic                          iValid,
  output logic                          oReady,
  input  logic                          iHold,
  input  logic                          iBreak,
  output logic                          oTX,
  output logic                          oBusy,
  output logic [$clog2(FIFO_DEPTH):0]   oLevel,
  output logic                          oOverflow
);

  localparam int unsigned CntW = $clog2(DIVISOR);
  localparam logic [CntW-1:0]    CntMax   = CntW'(DIVISOR - 1);
  localparam logic [BitCntW-1:0] LastData = BitCntW'(DATA_BITS - 1);
  localparam logic [BitCntW-1:0] LastStop = BitCntW'(STOP_BITS - 1);
  localparam logic [BitCntW-1:0] LastGap  = BitCntW'((GAP_BITS == 0) ? 0 : GAP_BITS - 1);
  localparam parity_e ParMode = parity_e'(PARITY[1:0]);
  localparam bit HasGap = (GAP_BITS != 0);

  tx_state_e            state_q;
  logic [CntW-1:0]      cnt_q;
  logic [BitCntW-1:0]   bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 tx_q;
  logic                 after_brk_q;
  logic                 ovf_q;

  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full, fifo_empty;
  logic                 push, pop;
  logic                 bit_end, frame_end, boundary, start_brk, rdata_par;

  eprisc_sync_fifo #(
    .Width (DATA_BITS),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (iBoardClock),
    .rst_i   (iBoardReset),
    .wdata_i (iData),
    .push_i  (push),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (oLevel)
  );

  // The frame boundary decision is taken on the last cycle of a frame as well as in idle,
  // so queued bytes go out back-to-back with no idle cycle between frames.
  always_comb begin
    push      = iValid && !fifo_full;
    bit_end   = (cnt_q == CntMax);
    frame_end = bit_end &&
                ((state_q == StStop && bit_cnt_q == LastStop && (!HasGap || after_brk_q)) ||
                 (state_q == StGap && bit_cnt_q == LastGap));
    boundary  = (state_q == StIdle) || frame_end;
    start_brk = boundary && iBreak;
    pop       = boundary && !iBreak && !iHold && !fifo_empty;
    rdata_par = (ParMode == ParOdd) ? ~^fifo_rdata : ^fifo_rdata;
  end

  always_ff @(posedge iBoardClock or posedge iBoardReset) begin
    if (iBoardReset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tx_q        <= 1'b1;
      after_brk_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      ovf_q <= iValid && fifo_full;
      if (start_brk) begin
        state_q <= StBreak;
        cnt_q   <= '0;
        tx_q    <= 1'b0;
      end else if (pop) begin
        state_q     <= StStart;
        cnt_q       <= '0;
        shift_q     <= fifo_rdata;
        par_q       <= rdata_par;
        after_brk_q <= 1'b0;
        tx_q        <= 1'b0;
      end else if (frame_end) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        tx_q    <= 1'b1;
      end else begin
        case (state_q)
          StIdle: begin
            tx_q <= 1'b1;
          end
          StBreak: begin
            // One forced idle-high bit time follows the release of a break.
            if (!iBreak) begin
              state_q     <= StStop;
              cnt_q       <= '0;
              bit_cnt_q   <= LastStop;
              after_brk_q <= 1'b1;
              tx_q        <= 1'b1;
            end
          end
          default: begin
            if (!bit_end) begin
              cnt_q <= cnt_q + 1'b1;
            end else begin
              cnt_q <= '0;
              case (state_q)
                StStart: begin
                  state_q   <= StData;
                  bit_cnt_q <= '0;
                  tx_q      <= shift_q[0];
                end
                StData: begin
                  if (bit_cnt_q == LastData) begin
                    bit_cnt_q <= '0;
                    if (ParMode != ParNone) begin
                      state_q <= StParity;
                      tx_q    <= par_q;
                    end else begin
                      state_q <= StStop;
                      tx_q    <= 1'b1;
                    end
                  end else begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    shift_q   <= shift_q >> 1;
                    tx_q      <= shift_q[1];
                  end
                end
                StParity: begin
                  state_q   <= StStop;
                  bit_cnt_q <= '0;
                  tx_q      <= 1'b1;
                end
                StStop: begin
                  tx_q <= 1'b1;
                  if (bit_cnt_q == LastStop) begin
                    state_q   <= StGap;
                    bit_cnt_q <= '0;
                  end else begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
                end
                StGap: begin
                  tx_q      <= 1'b1;
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                end
                default: begin
                  state_q <= StIdle;
                  tx_q    <= 1'b1;
                end
              endcase
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    oTX       = tx_q;
    oBusy     = (state_q != StIdle);
    oReady    = !fifo_full;
    oOverflow = ovf_q;
  end

endmodule

// File: tb/tb_eprisc_serial_tx.sv
// Directed bench for eprisc_serial_tx: default 8N1 instance plus two DIVISOR=4 parity instances.
module tb_eprisc_serial_tx;

  typedef struct packed {
    logic       tx;
    logic       busy;
    logic       ovf;
    logic [3:0] lvl;
  } samp_t;

  logic       clk, rst;
  logic [7:0] data;
  logic       valid, valid_e, valid_o, hold, brk;
  logic       tx, ready, busy, ovf;
  logic       tx_e, ready_e, busy_e, ovf_e;
  logic       tx_o, ready_o, busy_o, ovf_o;
  logic [2:0] level, level_e, level_o;
  int         sel;
  samp_t      mon;
  samp_t      log_q[$];
  int         n_total, n_bad;
  int         base;

  eprisc_serial_tx dut (
    .iBoardClock (clk), .iBoardReset (rst), .iData (data), .iValid (valid),
    .oReady (ready), .iHold (hold), .iBreak (brk), .oTX (tx), .oBusy (busy),
    .oLevel (level), .oOverflow (ovf)
  );

  eprisc_serial_tx #(.DIVISOR (4), .PARITY (2), .STOP_BITS (2)) dut_even (
    .iBoardClock (clk), .iBoardReset (rst), .iData (data), .iValid (valid_e),
    .oReady (ready_e), .iHold (1'b0), .iBreak (1'b0), .oTX (tx_e), .oBusy (busy_e),
    .oLevel (level_e), .oOverflow (ovf_e)
  );

  eprisc_serial_tx #(.DIVISOR (4), .PARITY (1), .STOP_BITS (2)) dut_odd (
    .iBoardClock (clk), .iBoardReset (rst), .iData (data), .iValid (valid_o),
    .oReady (ready_o), .iHold (1'b0), .iBreak (1'b0), .oTX (tx_o), .oBusy (busy_o),
    .oLevel (level_o), .oOverflow (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (sel)
      1:       mon = '{tx: tx_e, busy: busy_e, ovf: ovf_e, lvl: {1'b0, level_e}};
      2:       mon = '{tx: tx_o, busy: busy_o, ovf: ovf_o, lvl: {1'b0, level_o}};
      default: mon = '{tx: tx, busy: busy, ovf: ovf, lvl: {1'b0, level}};
    endcase
  end

  always @(negedge clk) log_q.push_back(mon);

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int count_tx(input int s, input int n, input logic v);
    int c = 0;
    for (int i = s; i < s + n; i++) if (i < log_q.size() && log_q[i].tx === v) c++;
    return c;
  endfunction

  function automatic int count_busy(input int s, input int n);
    int c = 0;
    for (int i = s; i < s + n; i++) if (i < log_q.size() && log_q[i].busy === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_ovf(input int s, input int n);
    int c = 0;
    for (int i = s; i < s + n; i++) if (i < log_q.size() && log_q[i].ovf === 1'b1) c++;
    return c;
  endfunction

  function automatic int peak_lvl(input int s, input int n);
    int p = 0;
    for (int i = s; i < s + n; i++) if (i < log_q.size() && int'(log_q[i].lvl) > p) p = log_q[i].lvl;
    return p;
  endfunction

  // 8N1 line pattern, LSB first: start 0, data, stop 1.
  function automatic logic [15:0] frame_pat(input logic [7:0] b);
    return {6'b0, 1'b1, b, 1'b0};
  endfunction

  task automatic check_frame(input string tag, input int fbase, input int nbits, input int div,
                             input logic [15:0] pat);
    for (int i = 0; i < nbits; i++)
      check_eq($sformatf("%s bit%0d", tag, i), count_tx(fbase + i * div, div, pat[i]), div);
  endtask

  initial begin
    n_total = 0; n_bad = 0; sel = 0;
    rst = 1'b1; data = 8'h00; valid = 0; valid_e = 0; valid_o = 0; hold = 0; brk = 0;
    repeat (3) tick();
    @(negedge clk);
    check_eq("rst tx", tx, 1);
    check_eq("rst busy", busy, 0);
    check_eq("rst ready", ready, 1);
    check_eq("rst level", level, 0);
    check_eq("rst ovf", ovf, 0);
    @(posedge clk); #1 rst = 1'b0;
    tick();

    // Even parity, 2 stop, DIVISOR=4, 0x41 -> parity bit 0, 48-cycle frame.
    sel = 1; data = 8'h41; valid_e = 1;
    tick(); valid_e = 0; base = log_q.size();
    repeat (60) tick();
    check_frame("even", base + 1, 12, 4, 16'h0C82);
    check_eq("even idle", count_tx(base + 49, 8, 1'b1), 8);
    check_eq("even busy", count_busy(base, 60), 48);

    // Odd parity variant -> parity bit 1.
    sel = 2; data = 8'h41; valid_o = 1;
    tick(); valid_o = 0; base = log_q.size();
    repeat (60) tick();
    check_frame("odd", base + 1, 12, 4, 16'h0E82);
    check_eq("odd busy", count_busy(base, 60), 48);

    // Single default frame 0x31.
    sel = 0; data = 8'h31; valid = 1;
    tick(); valid = 0; base = log_q.size();
    repeat (2700) tick();
    check_eq("f31 latency", log_q[base].tx, 1);
    check_frame("f31", base + 1, 10, 256, frame_pat(8'h31));
    check_eq("f31 busy", count_busy(base, 2700), 2560);
    check_eq("f31 idle", count_tx(base + 2561, 100, 1'b1), 100);

    // Four back-to-back frames.
    data = 8'h31; valid = 1;
    tick(); base = log_q.size();
    data = 8'h2E; tick();
    data = 8'h41; tick();
    data = 8'h0D; tick();
    valid = 0;
    repeat (10400) tick();
    check_frame("b2b0", base + 1, 10, 256, frame_pat(8'h31));
    check_frame("b2b1", base + 1 + 2560, 10, 256, frame_pat(8'h2E));
    check_frame("b2b2", base + 1 + 5120, 10, 256, frame_pat(8'h41));
    check_frame("b2b3", base + 1 + 7680, 10, 256, frame_pat(8'h0D));
    check_eq("b2b busy", count_busy(base, 10400), 10240);
    check_eq("b2b peak", peak_lvl(base, 10400), 3);
    check_eq("b2b no ovf", count_ovf(base, 10400), 0);

    // Fill FIFO behind a busy line, then one rejected write.
    data = 8'h10; valid = 1;
    tick(); base = log_q.size();
    data = 8'hA1; tick();
    data = 8'hA2; tick();
    data = 8'hA3; tick();
    data = 8'hA4; tick();
    data = 8'hEE;
    @(negedge clk);
    check_eq("full ready", ready, 0);
    check_eq("full level", level, 4);
    tick(); valid = 0;
    repeat (13200) tick();
    check_eq("ovf pulse", log_q[base + 5].ovf, 1);
    check_eq("ovf count", count_ovf(base, 13200), 1);
    check_frame("fill0", base + 1, 10, 256, frame_pat(8'h10));
    check_frame("fill1", base + 1 + 2560, 10, 256, frame_pat(8'hA1));
    check_frame("fill4", base + 1 + 10240, 10, 256, frame_pat(8'hA4));
    check_eq("fill busy", count_busy(base, 13200), 12800);
    check_eq("fill idle", count_tx(base + 12801, 300, 1'b1), 300);

    // Hold before write: nothing sent while held.
    hold = 1; data = 8'h5A; valid = 1;
    tick(); valid = 0; base = log_q.size();
    repeat (600) tick();
    check_eq("hold busy", count_busy(base, 600), 0);
    check_eq("hold tx", count_tx(base, 600, 1'b1), 600);
    check_eq("hold level", log_q[base + 599].lvl, 1);

    // Release; queue another byte; raise hold mid-frame.
    hold = 0; base = log_q.size();
    data = 8'h3C; valid = 1;
    tick(); valid = 0;
    repeat (1000) tick();
    hold = 1;
    repeat (2960) tick();
    check_eq("rel latency", log_q[base].tx, 1);
    check_frame("hold5a", base + 1, 10, 256, frame_pat(8'h5A));
    check_eq("held idle", count_tx(base + 2561, 400, 1'b1), 400);
    check_eq("held busy", count_busy(base + 2561, 400), 0);

    // Break for 1000 cycles while idle with 0x3C still queued.
    brk = 1; hold = 0; base = log_q.size();
    repeat (1000) tick();
    brk = 0;
    repeat (2900) tick();
    check_eq("brk pre", log_q[base].tx, 1);
    check_eq("brk low", count_tx(base + 1, 1000, 1'b0), 1000);
    check_eq("brk stop", count_tx(base + 1001, 256, 1'b1), 256);
    check_frame("brk3c", base + 1257, 10, 256, frame_pat(8'h3C));
    check_eq("brk busy", count_busy(base + 1, 3816), 3816);

    // Asynchronous reset mid-frame.
    data = 8'h00; valid = 1;
    tick();
    data = 8'hFF; tick();
    tick(); valid = 0;
    repeat (300) tick();
    @(negedge clk);
    check_eq("pre rst tx", tx, 0);
    check_eq("pre rst level", level, 2);
    rst = 1'b1;
    #1;
    check_eq("arst tx", tx, 1);
    check_eq("arst level", level, 0);
    check_eq("arst busy", busy, 0);
    check_eq("arst ready", ready, 1);
    @(posedge clk); #1 rst = 1'b0;
    base = log_q.size();
    repeat (600) tick();
    check_eq("post rst busy", count_busy(base, 600), 0);
    check_eq("post rst tx", count_tx(base, 600, 1'b1), 600);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/eprisc_serial_tx.md
# eprisc_serial_tx

Parametrised, buffered asynchronous serial transmitter that generates framed start/data/parity/stop bit streams on a single line. It serves as the synthesizable TX engine for the I/O controller's TTL and RS-232 ports. It also replaces hand-timed bit toggling in benches: its output drives a serial RX pin directly. Bytes are queued through a small FIFO and sent back-to-back, with optional flow-control hold and line-break generation.

## Interface
- DATA_BITS, 8, data bits per frame, legal 5–9, sent LSB first
- DIVISOR, 256, clock cycles per bit time, ≥2
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, 1 or 2
- GAP_BITS, 0, idle-high bit times inserted after every frame, 0–15
- FIFO_DEPTH, 4, entries, power of two ≥2
- iBoardClock  in  1  sole clock
- iBoardReset  in  1  asynchronous, active-high reset
- iData  in  DATA_BITS  byte to enqueue
- iValid  in  1  enqueue request
- oReady  out  1  FIFO not full
- iHold  in  1  flow control; sampled only at frame boundaries
- iBreak  in  1  request line break (continuous low)
- oTX  out  1  serial line, idle high
- oBusy  out  1  frame, gap or break in progress
- oLevel  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- oOverflow  out  1  one-cycle pulse when iValid is high while oReady is low

## Operation
- Write handshake: a write occurs on an edge where iValid && oReady. oReady derives from the registered count only. When full, oReady stays 0 even if a pop happens on the same edge; the write is dropped and oOverflow pulses.
- A simultaneous push and pop with a non-full, non-empty FIFO leaves oLevel unchanged.
- FSM states and transitions:
  - IDLE → BREAK: when iBreak is high.
  - IDLE → START: when iBreak is low, iHold is low and the FIFO is non-empty. The pop happens on this transition.
  - IDLE otherwise: stay in IDLE.
  - START → DATA (DATA_BITS bits) → PARITY (only if PARITY≠0) → STOP (STOP_BITS bits) → GAP (only if GAP_BITS≠0) → IDLE.
  - BREAK: oTX=0 while iBreak is high. After iBreak falls, go to STOP for one bit time (forced idle high), then IDLE.
- Parity is computed over the DATA_BITS data bits. Odd parity makes the total count of 1s in data+parity odd.
- Bit-time counter counts 0..DIVISOR-1 and wraps. The bit counter sequences within DATA and STOP.
- oBusy is 1 in every state except IDLE.
- iHold and iBreak asserted mid-frame have no effect until the frame, including its gap, completes.
- Reset mid-frame: oTX goes to 1 immediately (asynchronous), the FIFO empties, the FSM returns to IDLE, and the partially sent frame is abandoned.
- Reset values: oTX=1, oBusy=0, oReady=1, oLevel=0, oOverflow=0.

## Timing
- oTX is registered.
- Latency: write at edge E0 into an empty FIFO with the FSM idle. E1 pops the entry and oTX=0 after E1, so the start bit appears 2 edges after the write.
- Each bit is exactly DIVISOR cycles.
- Frame length is (1 + DATA_BITS + (PARITY≠0) + STOP_BITS + GAP_BITS) × DIVISOR cycles.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop/gap cycle, with no idle cycle between frames.
- oLevel updates on the edge of the push or pop.
- oOverflow is high for exactly the cycle following the rejected edge.

## Structure
- Shared package eprisc_serial_pkg holds:
  - parity enum (NONE/ODD/EVEN)
  - FSM state enum
  - function frame_cycles(DATA_BITS, PARITY, STOP_BITS, GAP_BITS, DIVISOR)
- The package is reused by the planned receiver and by benches.
- Sub-module eprisc_sync_fifo (parametrised width/depth, registered count, full/empty) is instantiated once.
- The FSM, counters and shift register live in the top module.

## Test plan
- Defaults, write 0x31 → oTX: 0 for 256 cycles, then 1,0,0,0,1,1,0,0 at 256 cycles each, then 1 for 256. oBusy high for exactly 2560 cycles.
- Write 0x31, 0x2E, 0x41, 0x0D on consecutive edges → four contiguous frames, 10240 cycles total, no idle gap. oLevel peaks at 3.
- PARITY=2, STOP_BITS=2, DIVISOR=4, write 0x41 → parity bit 0 followed by two stop bits, 48-cycle frame. PARITY=1 gives parity bit 1.
- Fill the FIFO (4 writes while the line is busy), then a fifth write → oReady=0 and one oOverflow pulse. The fifth byte never appears on oTX.
- iHold high before a write → no start bit while held. Release → start bit 2 edges after release. iHold raised mid-frame → the current frame completes.
- iBreak high 1000 cycles while idle → oTX low for 1000 cycles, then high for 256 cycles before the queued frame. Reset pulse mid-frame → oTX=1 immediately, oLevel=0.
